// File: rtl/alu_fu_unit_pkg.sv
// Shared types for the integer ALU functional unit: widths, op encoding, control word,
// result record and FSM states.
package alu_fu_unit_pkg;

    localparam int REG_VAL_WIDTH          = 32;
    localparam int INST_ADDR_WIDTH        = 32;
    localparam int PHYSICAL_REG_NUM_WIDTH = 6;
    localparam int ROB_SIZE_WIDTH         = 5;

    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL,
        BEQ, BNE, BLT, BGE, BLTU, BGEU
    } alu_op_t;

    typedef enum logic {
        src_reg2,
        src_imm
    } alu_src_t;

    typedef struct packed {
        alu_op_t  alu_op;
        alu_src_t alu_src;
        logic     is_branch_op;
    } control_t;

    typedef struct packed {
        logic [REG_VAL_WIDTH-1:0]          val;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr;
        logic [ROB_SIZE_WIDTH-1:0]         inst_tag;
        logic                              is_branch;
        logic                              taken;
        logic [INST_ADDR_WIDTH-1:0]        target;
    } fu_result_t;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } fu_state_t;

    // A MUL opcode tagged as a branch is treated as a branch, not a multiply.
    function automatic logic is_mul_op(control_t c);
        return (c.alu_op == MUL) && !c.is_branch_op;
    endfunction

endpackage

// File: rtl/alu_fu_unit_if.sv
// FU slot bundle: dispatch side (in_*) from the reservation station and result
// side (out_*) towards the CDB arbiter.
interface alu_fu_unit_if;
    import alu_fu_unit_pkg::*;

    // Handshake: an op transfers on a cycle where in_valid && in_ready; a result
    // leaves the buffer on a cycle where out_valid && out_grant.
    logic                              in_valid;
    logic                              in_ready;
    control_t                          in_control;
    logic [REG_VAL_WIDTH-1:0]          in_src1_val;
    logic [REG_VAL_WIDTH-1:0]          in_src2_val;
    logic [REG_VAL_WIDTH-1:0]          in_immediate;
    logic [INST_ADDR_WIDTH-1:0]        in_pc;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] in_dst_reg_addr;
    logic [ROB_SIZE_WIDTH-1:0]         in_inst_tag;

    logic                              out_valid;
    logic                              out_grant;
    logic [REG_VAL_WIDTH-1:0]          out_val;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] out_dst_reg_addr;
    logic [ROB_SIZE_WIDTH-1:0]         out_inst_tag;
    logic                              out_is_branch;
    logic                              out_branch_taken;
    logic [INST_ADDR_WIDTH-1:0]        out_branch_target;

    modport master (
        output in_valid, in_control, in_src1_val, in_src2_val, in_immediate,
               in_pc, in_dst_reg_addr, in_inst_tag, out_grant,
        input  in_ready, out_valid, out_val, out_dst_reg_addr, out_inst_tag,
               out_is_branch, out_branch_taken, out_branch_target
    );

    modport slave (
        input  in_valid, in_control, in_src1_val, in_src2_val, in_immediate,
               in_pc, in_dst_reg_addr, in_inst_tag, out_grant,
        output in_ready, out_valid, out_val, out_dst_reg_addr, out_inst_tag,
               out_is_branch, out_branch_taken, out_branch_target
    );

endinterface

// File: rtl/alu_fu_unit_alu_core.sv
// Combinational datapath: op + operands -> result value and branch-taken flag.
module alu_core
    import alu_fu_unit_pkg::*;
(
    input  alu_op_t                  op,
    input  logic                     is_branch,
    input  logic [REG_VAL_WIDTH-1:0] a,
    input  logic [REG_VAL_WIDTH-1:0] b,
    output logic [REG_VAL_WIDTH-1:0] val,
    output logic                     taken
);

    localparam int SHW = $clog2(REG_VAL_WIDTH);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    assign shamt = b[SHW-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        val   = '0;
        taken = 1'b0;
        if (is_branch) begin
            // Branches report only the condition; the value field stays zero.
            unique case (op)
                BEQ:     taken = (a == b);
                BNE:     taken = (a != b);
                BLT:     taken = lt_s;
                BGE:     taken = !lt_s;
                BLTU:    taken = lt_u;
                BGEU:    taken = !lt_u;
                default: taken = 1'b0;
            endcase
        end else begin
            unique case (op)
                ADD:     val = a + b;
                SUB:     val = a - b;
                AND:     val = a & b;
                OR:      val = a | b;
                XOR:     val = a ^ b;
                SLL:     val = a << shamt;
                SRL:     val = a >> shamt;
                SRA:     val = $signed(a) >>> shamt;
                SLT:     val = {{(REG_VAL_WIDTH-1){1'b0}}, lt_s};
                SLTU:    val = {{(REG_VAL_WIDTH-1){1'b0}}, lt_u};
                MUL:     val = a * b;
                default: val = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_fu_unit.sv
// ALU functional unit: single-cycle ALU/branch ops, multi-cycle MUL, and a
// one-entry result buffer that drains when the CDB arbiter grants it.
module alu_fu_unit
    import alu_fu_unit_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic          clk,
    input  logic          reset,
    alu_fu_unit_if.slave  fu,
    output fu_state_t     dbg_state
);

    localparam int CNT_W = 4;

    fu_state_t                         state, next_state;
    logic [CNT_W-1:0]                  cnt;
    logic [REG_VAL_WIDTH-1:0]          lat_a, lat_b;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] lat_dst;
    logic [ROB_SIZE_WIDTH-1:0]         lat_tag;

    fu_result_t                        out_buf, new_res;
    logic                              out_valid_q;

    logic                              buf_free, in_ready, accept, in_is_mul, load, busy;
    logic [REG_VAL_WIDTH-1:0]          op2, core_a, core_b, core_val;
    alu_op_t                           core_op;
    logic                              core_branch, core_taken;

    assign busy      = (state == MUL_BUSY);
    assign buf_free  = !out_valid_q || fu.out_grant;
    assign in_ready  = (state == IDLE) && buf_free;
    assign accept    = fu.in_valid && in_ready;
    assign in_is_mul = is_mul_op(fu.in_control);

    // Branches always compare against src2, whatever alu_src says.
    assign op2 = (fu.in_control.is_branch_op || fu.in_control.alu_src == src_reg2)
               ? fu.in_src2_val : fu.in_immediate;

    // While a MUL is in flight the core works on the latched operands.
    assign core_op     = busy ? MUL   : fu.in_control.alu_op;
    assign core_branch = busy ? 1'b0  : fu.in_control.is_branch_op;
    assign core_a      = busy ? lat_a : fu.in_src1_val;
    assign core_b      = busy ? lat_b : op2;

    alu_core u_core (
        .op        (core_op),
        .is_branch (core_branch),
        .a         (core_a),
        .b         (core_b),
        .val       (core_val),
        .taken     (core_taken)
    );

    always_comb begin
        new_res              = '0;
        new_res.val          = core_val;
        new_res.dst_reg_addr = busy ? lat_dst : fu.in_dst_reg_addr;
        new_res.inst_tag     = busy ? lat_tag : fu.in_inst_tag;
        new_res.is_branch    = core_branch;
        new_res.taken        = core_taken;
        new_res.target       = busy ? '0 : fu.in_pc + fu.in_immediate[INST_ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load = !in_is_mul;
                    if (in_is_mul) next_state = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                // Finish only once the buffer can take the product; otherwise hold at cnt==1.
                if (cnt == CNT_W'(1) && buf_free) begin
                    load       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept && in_is_mul) begin
            cnt <= CNT_W'(MUL_LATENCY - 1);
        end else if (busy) begin
            if (load)                 cnt <= '0;
            else if (cnt > CNT_W'(1)) cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && in_is_mul) begin
            lat_a   <= fu.in_src1_val;
            lat_b   <= op2;
            lat_dst <= fu.in_dst_reg_addr;
            lat_tag <= fu.in_inst_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_buf     <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_buf     <= new_res;
        end else if (fu.out_grant) begin
            out_valid_q <= 1'b0;
        end
    end

    assign fu.in_ready          = in_ready;
    assign fu.out_valid         = out_valid_q;
    assign fu.out_val           = out_buf.val;
    assign fu.out_dst_reg_addr  = out_buf.dst_reg_addr;
    assign fu.out_inst_tag      = out_buf.inst_tag;
    assign fu.out_is_branch     = out_buf.is_branch;
    assign fu.out_branch_taken  = out_buf.taken;
    assign fu.out_branch_target = out_buf.target;
    assign dbg_state            = state;

endmodule
